// File: rtl/math_add_96_pkg.sv
// rtl/math_add_96_pkg.sv - widths, latencies and in-flight tag type for the shared 96-bit adder
package math_add_96_pkg;

    localparam int ADD96_W     = 96;
    localparam int ADD96_SUM_W = 97;
    localparam int ADD96_LAT   = 3;
    localparam int ARB_LAT     = ADD96_LAT + 1;
    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W    = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } add96_tag_t;

endpackage

// File: rtl/math_rr_arb.sv
// rtl/math_rr_arb.sv - round-robin grant with pointer register; MATH_ADD_96_ARB_PRIO0_EN gives requester 0 absolute priority
module math_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic            found;
    logic            prio_hit;
    int              idx;

    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
`ifdef MATH_ADD_96_ARB_PRIO0_EN
        prio_hit = req[0];
        if (prio_hit) begin
            found    = 1'b1;
            grant_id = '0;
        end
`else
        prio_hit = 1'b0;
`endif
        grant_valid = en & found;
        grant       = grant_valid ? (NUM_REQ'(1) << grant_id) : '0;
    end

    // A priority grant to requester 0 leaves the rotation where it was.
    always_comb begin
        ptr_nxt = ptr;
        if (grant_valid && !prio_hit) begin
            ptr_nxt = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/math_add_96_arb.sv
// rtl/math_add_96_arb.sv - shares one 96-bit adder among NUM_REQ requesters and routes sums back by tag
// Optional: MATH_ADD_96_ARB_PRIO0_EN (requester 0 absolute priority, implemented in math_rr_arb).
module math_add_96_arb
    import math_add_96_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hold,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADD96_W-1:0] req_dina,
    input  logic [NUM_REQ*ADD96_W-1:0] req_dinb,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [ADD96_SUM_W-1:0]     rsp_sum,
    output logic                       add_ena,
    output logic                       add_rst,
    output logic [ADD96_W-1:0]         add_dina,
    output logic [ADD96_W-1:0]         add_dinb,
    input  logic [ADD96_SUM_W-1:0]     add_dout
);

    logic               rst_q;
    logic [ID_W-1:0]    grant_id;
    logic               grant_valid;
    logic [ADD96_W-1:0] sel_a;
    logic [ADD96_W-1:0] sel_b;
    add96_tag_t         tag_pipe [ARB_LAT];
    add96_tag_t         tag_out;

    // Stretches the adder reset one clock past rst; ena must stay low meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
        end
    end

    assign add_rst = rst_q;
    assign add_ena = ~rst_q & ~hold;

    math_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arb (
        .clk         (clk),
        .rst         (rst),
        .en          (add_ena),
        .req         (req_valid),
        .grant       (req_ready),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_a = req_dina[int'(grant_id)*ADD96_W +: ADD96_W];
        sel_b = req_dinb[int'(grant_id)*ADD96_W +: ADD96_W];
    end

    // Tag stages advance only with add_ena so they stay aligned with the adder pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_dina <= '0;
            add_dinb <= '0;
            for (int i = 0; i < ARB_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else if (add_ena) begin
            if (grant_valid) begin
                add_dina <= sel_a;
                add_dinb <= sel_b;
            end
            tag_pipe[0].valid <= grant_valid;
            tag_pipe[0].id    <= TAG_ID_W'(grant_id);
            for (int i = 1; i < ARB_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out   = tag_pipe[ARB_LAT-1];
    assign rsp_valid = (tag_out.valid && add_ena) ? (NUM_REQ'(1) << tag_out.id) : '0;
    assign rsp_sum   = add_dout;

endmodule

// File: tb/tb_math_add_96_arb.sv
// tb/tb_math_add_96_arb.sv - directed bench with scoreboard model for math_add_96_arb
module tb_math_add_96_arb;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hold;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*96-1:0] req_dina;
    logic [N*96-1:0] req_dinb;
    logic [N-1:0]  rsp_valid;
    logic [96:0]   rsp_sum;
    logic          add_ena;
    logic          add_rst;
    logic [95:0]   add_dina;
    logic [95:0]   add_dinb;
    logic [96:0]   add_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    math_add_96_arb #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dina  (req_dina),
        .req_dinb  (req_dinb),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .add_ena   (add_ena),
        .add_rst   (add_rst),
        .add_dina  (add_dina),
        .add_dinb  (add_dinb),
        .add_dout  (add_dout)
    );

    // Three-stage adder stand-in: honours rst only while ena is low.
    logic [96:0] s1, s2, s3;
    always @(posedge clk) begin
        if (add_ena) begin
            s1 <= {1'b0, add_dina} + {1'b0, add_dinb};
            s2 <= s1;
            s3 <= s2;
        end else if (add_rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end
    end
    assign add_dout = s3;

    typedef struct {
        int          id;
        logic [96:0] sum;
        logic [95:0] a;
        logic [95:0] b;
        int          cnt;
    } item_t;

    item_t q[$];
    int    ptr_m   = 0;
    bit    rst_tail = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_grant(input bit en);
        if (!en) return '0;
`ifdef MATH_ADD_96_ARB_PRIO0_EN
        if (req_valid[0]) return 4'b0001;
`endif
        for (int i = 0; i < N; i++) begin
            int idx = (ptr_m + i) % N;
            if (req_valid[idx]) return 4'(1 << idx);
        end
        return '0;
    endfunction

    // Model state advances on each edge: items age by one per enabled clock.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            ptr_m    = 0;
            rst_tail = 1'b1;
        end else begin
            bit          en;
            logic [N-1:0] g;
            en = !rst_tail && !hold;
            g  = exp_grant(en);
            if (en) begin
                if (q.size() > 0 && q[0].cnt == 4) void'(q.pop_front());
                foreach (q[j]) q[j].cnt++;
                for (int i = 0; i < N; i++) begin
                    if (g[i]) begin
                        item_t it;
                        bit    prio;
                        it.id  = i;
                        it.a   = req_dina[i*96 +: 96];
                        it.b   = req_dinb[i*96 +: 96];
                        it.sum = {1'b0, it.a} + {1'b0, it.b};
                        it.cnt = 1;
                        q.push_back(it);
                        prio = 1'b0;
`ifdef MATH_ADD_96_ARB_PRIO0_EN
                        prio = (i == 0) && req_valid[0];
`endif
                        if (!prio) ptr_m = (i + 1) % N;
                    end
                end
            end
            rst_tail = 1'b0;
        end
    end

    initial forever begin
        bit           er, en;
        logic [N-1:0] g, ev;
        logic [96:0]  es;
        @(negedge clk);
        er = rst || rst_tail;
        en = !er && !hold;
        g  = exp_grant(en);
        ev = '0;
        es = '0;
        foreach (q[j]) begin
            if (q[j].cnt == 4 && en) begin
                ev = 4'(1 << q[j].id);
                es = q[j].sum;
            end
            if (q[j].cnt == 1) begin
                chk("add_dina", 128'(add_dina), 128'(q[j].a));
                chk("add_dinb", 128'(add_dinb), 128'(q[j].b));
            end
        end
        chk("req_ready", 128'(req_ready), 128'(g));
        chk("add_rst", 128'(add_rst), 128'(er));
        chk("add_ena", 128'(add_ena), 128'(en));
        chk("rsp_valid", 128'(rsp_valid), 128'(ev));
        if (ev != '0) chk("rsp_sum", 128'(rsp_sum), 128'(es));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [95:0] a, input logic [95:0] b);
        req_dina[i*96 +: 96] = a;
        req_dinb[i*96 +: 96] = b;
    endtask

    initial begin
        logic [3:0]  one;
        logic [31:0] w;
        hold      = 1'b0;
        req_valid = '0;
        req_dina  = '0;
        req_dinb  = '0;
        one       = 4'b0001;
        #1 rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_add_dina", 128'(add_dina), 128'(0));
        chk("rst_add_dinb", 128'(add_dinb), 128'(0));
        chk("rst_add_rst", 128'(add_rst), 128'(1));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("tail_add_rst", 128'(add_rst), 128'(1));
        chk("tail_add_ena", 128'(add_ena), 128'(0));
        tick();
        @(negedge clk);
        chk("post_add_rst", 128'(add_rst), 128'(0));
        chk("post_add_ena", 128'(add_ena), 128'(1));
        tick();

        // Single request through the full carry chain.
        req_valid = 4'b0100;
        set_ops(2, {96{1'b1}}, 96'h1);
        @(negedge clk);
        chk("t1_ready", 128'(req_ready), 128'(4'b0100));
        tick();
        req_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("t1_rsp_valid", 128'(rsp_valid), 128'(4'b0100));
        chk("t1_rsp_sum", 128'(rsp_sum), 128'(97'h1_0000_0000_0000_0000_0000_0000));
        repeat (2) tick();

        // Reset back to pointer 0, then all four requesting.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 8; k++) begin
            req_valid = 4'hF;
            for (int i = 0; i < N; i++) begin
                w = 32'h0000_1000 * 32'(k + 1) + 32'(i);
                set_ops(i, {32'hFFFF_FFFF, 32'hFFFF_FFFF, w}, {64'h0, 32'hFFFF_F000 ^ 32'(k)});
            end
            @(negedge clk);
            chk("t2_order", 128'(req_ready), 128'(one << (k % 4)));
            tick();
        end
        req_valid = '0;
        repeat (6) tick();

        // Two in flight, then hold for three cycles as the first comes due.
        req_valid = 4'b0001;
        set_ops(0, 96'h1234_5678_9ABC_DEF0_0000_0001, 96'h0000_0000_0000_0000_FFFF_FFFF);
        tick();
        req_valid = 4'b0010;
        set_ops(1, 96'h8000_0000_0000_0000_0000_0000, 96'h8000_0000_0000_0000_0000_0000);
        tick();
        req_valid = '0;
        repeat (2) tick();
        hold      = 1'b1;
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_hold_rsp", 128'(rsp_valid), 128'(0));
            chk("t3_hold_ready", 128'(req_ready), 128'(0));
            tick();
        end
        hold      = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("t3_rsp0", 128'(rsp_valid), 128'(4'b0001));
        chk("t3_sum0", 128'(rsp_sum), 128'(97'h0_1234_5678_9ABC_DEF1_0000_0000));
        tick();
        @(negedge clk);
        chk("t3_rsp1", 128'(rsp_valid), 128'(4'b0010));
        chk("t3_sum1", 128'(rsp_sum), 128'(97'h1_0000_0000_0000_0000_0000_0000));
        tick();
        @(negedge clk);
        chk("t3_nodup", 128'(rsp_valid), 128'(0));
        repeat (2) tick();

        // Three issued, then reset discards them.
        req_valid = 4'b0100;
        set_ops(2, 96'h5, 96'h6);
        tick();
        req_valid = 4'b1000;
        set_ops(3, 96'h7, 96'h8);
        tick();
        req_valid = 4'b0001;
        set_ops(0, 96'h9, 96'hA);
        tick();
        req_valid = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_add_rst", 128'(add_rst), 128'(1));
        chk("t4_add_ena", 128'(add_ena), 128'(0));
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("t4_no_rsp", 128'(rsp_valid), 128'(0));
        end
        tick();
        req_valid = 4'b0010;
        set_ops(1, 96'h0000_0001_FFFF_FFFF_FFFF_FFFF, 96'h1);
        tick();
        req_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("t4_rsp_valid", 128'(rsp_valid), 128'(4'b0010));
        chk("t4_rsp_sum", 128'(rsp_sum), 128'(97'h0_0000_0002_0000_0000_0000_0000));
        tick();

        // Pointer now sits at 2.
        for (int i = 0; i < N; i++) set_ops(i, 96'(i + 1) << 60, 96'h3 << (8 * i));
`ifdef MATH_ADD_96_ARB_PRIO0_EN
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_prio0", 128'(req_ready), 128'(4'b0001));
            tick();
        end
        req_valid = 4'b1110;
        @(negedge clk);
        chk("t5_rr_a", 128'(req_ready), 128'(4'b0100));
        tick();
        @(negedge clk);
        chk("t5_rr_b", 128'(req_ready), 128'(4'b1000));
        tick();
        @(negedge clk);
        chk("t5_rr_c", 128'(req_ready), 128'(4'b0010));
        tick();
`else
        req_valid = 4'hF;
        @(negedge clk);
        chk("t5_rr_a", 128'(req_ready), 128'(4'b0100));
        tick();
        @(negedge clk);
        chk("t5_rr_b", 128'(req_ready), 128'(4'b1000));
        tick();
        @(negedge clk);
        chk("t5_rr_c", 128'(req_ready), 128'(4'b0001));
        tick();
        @(negedge clk);
        chk("t5_rr_d", 128'(req_ready), 128'(4'b0010));
        tick();
`endif
        req_valid = '0;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
